fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Producer side of the instruction queue: owns the PC, issues word fetches to the instruction cache, and pushes {pc, inst, flags} entries into the queue.
- Stalls on queue full through a one-entry hold buffer.
- Redirects on branch_mispredict. Responses belonging to a killed request are discarded.
- Sits between the icache and instruction_q. It drives the queue's load bit; dispatch owns the pop bit.

Parameters:
- RESET_PC, 32'h1eceb000, PC loaded at reset.
- IQ_WIDTH, 66, queue entry width. Must be 66.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- branch_mispredict  in  1  redirect request, one-cycle pulse.
- redirect_pc  in  32  target PC; valid when branch_mispredict=1.
- imem_addr  out  32  fetch address, word aligned.
- imem_rmask  out  4  4'hF while a request is outstanding, else 0.
- imem_rdata  in  32  instruction word; valid when imem_resp=1.
- imem_resp  in  1  one-cycle response strobe.
- iq_full  in  1  instruction queue full.
- iq_push  out  1  load request to the queue; the queue captures iq_entry on the clock edge.
- iq_entry  out  66  entry: [31:0]=inst, [63:32]=pc, [64]=valid, [65]=misaligned-PC fault.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH_REQ, kill=0, hold_valid=0.
  - imem_rmask=0, iq_push=0, iq_entry=0.
  - First request appears the cycle after rst deasserts.
- States:
  - FETCH_REQ: drive imem_addr=pc, imem_rmask=4'hF; go to FETCH_WAIT.
  - FETCH_WAIT: imem_addr and imem_rmask are held stable until imem_resp. A request is never aborted.
  - HOLD: a response is captured in the hold buffer and iq_full=1. Keep iq_push=1 (entry from the hold buffer) until iq_full=0, then go to FETCH_REQ with pc+4.
- On imem_resp in FETCH_WAIT with kill=0:
  - Build the entry from imem_rdata and pc, with valid=1.
  - If iq_full=0: iq_push=1 in the same cycle, pc<=pc+4, next state FETCH_REQ.
  - Otherwise: capture into the hold buffer and go to HOLD.
- Minimum fetch period is 2 cycles (request cycle, then response). An icache latency of L cycles gives a period of L+1.
- branch_mispredict in FETCH_REQ or HOLD:
  - pc<=redirect_pc; the hold buffer is dropped.
  - iq_push=0 that cycle.
  - Next state FETCH_REQ.
- branch_mispredict in FETCH_WAIT:
  - pc<=redirect_pc, kill<=1.
  - The matching response is consumed with no push, and kill is cleared.
  - Next state FETCH_REQ at redirect_pc.
- branch_mispredict in the same cycle as imem_resp:
  - The response is discarded (no push). pc<=redirect_pc, next state FETCH_REQ.
- Misaligned redirect_pc (bits[1:0]!=0):
  - No icache request is issued.
  - Push one entry with inst=32'h00000013 (nop), valid=1, fault=1, honouring iq_full.
  - Then halt in FETCH_WAIT-idle (rmask=0) until the next branch_mispredict.
- PC arithmetic: 32-bit, wraps 32'hFFFFFFFC -> 0 silently.
- iq_entry is meaningful only when iq_push=1; otherwise it is driven as 0.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {FETCH_REQ, FETCH_WAIT, HOLD, HALT}
  - iq_entry_t packed struct {fault, valid, pc[31:0], inst[31:0]}
  - NOP_INST constant
- Sub-module fetch_hold_reg: one-entry skid buffer with load, drop and valid.

Test Plan:
- Reset release, icache latency 1, iq_full=0 -> addr 1eceb000 then 1eceb004 on alternate cycles. Entries pushed with pc=1eceb000/…004, valid=1, fault=0.
- iq_full=1 for 5 cycles when the response for 1eceb008 arrives -> iq_push held for 5 cycles with the same entry. No new request until iq_full=0. Next addr 1eceb00c.
- branch_mispredict to 1eceb100 while waiting, icache latency 3 -> the old response is dropped (no push). Next request addr 1eceb100, and its entry is pushed.
- branch_mispredict in the same cycle as imem_resp -> no push; next addr = redirect_pc.
- redirect_pc=1eceb102 -> no request; one push of inst=00000013, pc=1eceb102, fault=1. rmask stays 0 until the next redirect to 1eceb200.
- rst asserted mid-wait -> all outputs 0 immediately (async). After release, the request restarts at 1eceb000; the stale response is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INST   = 32'h00000013;
    localparam logic [3:0]  RMASK_WORD = 4'hF;
    localparam int          IQ_ENTRY_W = 66;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic        fault;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    function automatic iq_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        fault
    );
        iq_entry_t e;
        e.fault = fault;
        e.valid = 1'b1;
        e.pc    = pc;
        e.inst  = inst;
        return e;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid buffer that parks a fetched entry while the queue is full.
module fetch_hold_reg
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      drop,
    input  iq_entry_t load_entry,
    output logic      valid,
    output iq_entry_t entry
);

    logic      valid_q, valid_d;
    iq_entry_t entry_q, entry_d;

    // A load wins over a drop so a parked entry can be replaced in one step.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (drop) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            entry_d = load_entry;
        end
    end

    // Buffer storage, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid = valid_q;
    assign entry = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, issues word fetches to the icache and pushes
// {fault, valid, pc, inst} entries into the instruction queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          IQ_WIDTH = 66
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_mispredict,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         imem_addr,
    output logic [3:0]          imem_rmask,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_resp,
    input  logic                iq_full,
    output logic                iq_push,
    output logic [IQ_WIDTH-1:0] iq_entry
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         kill_q, kill_d;
    logic         started_q, started_d;

    logic         hold_load;
    logic         hold_drop;
    iq_entry_t    hold_in;
    logic         hold_valid;
    iq_entry_t    hold_entry;
    iq_entry_t    entry_out;

    fetch_hold_reg u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .drop       (hold_drop),
        .load_entry (hold_in),
        .valid      (hold_valid),
        .entry      (hold_entry)
    );

    // Next-state and output logic; all outputs stay quiet until the first
    // clock after reset release so the first request lands one cycle later.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        kill_d     = kill_q;
        started_d  = 1'b1;
        imem_addr  = '0;
        imem_rmask = '0;
        iq_push    = 1'b0;
        entry_out  = '0;
        hold_load  = 1'b0;
        hold_drop  = 1'b0;
        hold_in    = '0;

        if (started_q) begin
            case (state_q)
                FETCH_REQ: begin
                    if (branch_mispredict) begin
                        pc_d = redirect_pc;
                    end else if (pc_q[1:0] != 2'b00) begin
                        if (iq_full) begin
                            hold_load = 1'b1;
                            hold_in   = make_entry(pc_q, NOP_INST, 1'b1);
                            state_d   = HOLD;
                        end else begin
                            iq_push   = 1'b1;
                            entry_out = make_entry(pc_q, NOP_INST, 1'b1);
                            state_d   = HALT;
                        end
                    end else begin
                        imem_addr  = pc_q;
                        imem_rmask = RMASK_WORD;
                        addr_d     = pc_q;
                        state_d    = FETCH_WAIT;
                    end
                end

                FETCH_WAIT: begin
                    imem_addr  = addr_q;
                    imem_rmask = RMASK_WORD;
                    if (imem_resp) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_REQ;
                        if (branch_mispredict) begin
                            pc_d = redirect_pc;
                        end else if (!kill_q) begin
                            if (iq_full) begin
                                hold_load = 1'b1;
                                hold_in   = make_entry(addr_q, imem_rdata, 1'b0);
                                state_d   = HOLD;
                            end else begin
                                iq_push   = 1'b1;
                                entry_out = make_entry(addr_q, imem_rdata, 1'b0);
                                pc_d      = addr_q + 32'd4;
                            end
                        end
                    end else if (branch_mispredict) begin
                        pc_d   = redirect_pc;
                        kill_d = 1'b1;
                    end
                end

                HOLD: begin
                    if (branch_mispredict) begin
                        hold_drop = 1'b1;
                        pc_d      = redirect_pc;
                        state_d   = FETCH_REQ;
                    end else begin
                        iq_push   = hold_valid;
                        entry_out = hold_entry;
                        if (!iq_full) begin
                            hold_drop = 1'b1;
                            if (hold_entry.fault) begin
                                state_d = HALT;
                            end else begin
                                pc_d    = pc_q + 32'd4;
                                state_d = FETCH_REQ;
                            end
                        end
                    end
                end

                HALT: begin
                    if (branch_mispredict) begin
                        pc_d    = redirect_pc;
                        state_d = FETCH_REQ;
                    end
                end

                default: begin
                    state_d = FETCH_REQ;
                end
            endcase
        end
    end

    // State, PC and request-address registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            addr_q    <= '0;
            kill_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            kill_q    <= kill_d;
            started_q <= started_d;
        end
    end

    assign iq_entry = entry_out;

endmodule
